// File: rtl/inc_sched_pkg.sv
// Shared types and helpers for the inc_sched round-robin increment scheduler.
package inc_sched_pkg;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_SLEEP = 2'd1,
    S_WAKE  = 2'd2
  } state_t;

  typedef enum logic {
    ID_A = 1'b0,
    ID_B = 1'b1
  } req_id_t;

  // Idle counter only needs to reach idle_cyc-1; keep at least one bit.
  function automatic int idle_cnt_w(input int idle_cyc);
    return (idle_cyc > 1) ? $clog2(idle_cyc) : 1;
  endfunction

endpackage

// File: rtl/inc_sched_rr_arb2.sv
// Two-way round-robin arbiter: on a tie, grants the requester that was not served last.
module rr_arb2
  import inc_sched_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_t    last,
  output logic [1:0] gnt,
  output req_id_t    gnt_id
);

  // NOTE: every output gets a default first so this block cannot infer a latch.
  always_comb begin
    gnt    = 2'b00;
    gnt_id = ID_A;
    if (req[ID_A] && (!req[ID_B] || last == ID_B)) begin
      gnt[ID_A] = 1'b1;
      gnt_id    = ID_A;
    end else if (req[ID_B]) begin
      gnt[ID_B] = 1'b1;
      gnt_id    = ID_B;
    end
  end

endmodule

// File: rtl/inc_sched.sv
// Round-robin scheduler for a shared increment datapath: count, enable, wrap pulse and idle sleep.
module inc_sched
  import inc_sched_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int STEPA    = 1,
  parameter int STEPB    = 1,
  parameter int IDLE_CYC = 4
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             REQA,
  input  logic             REQB,
  output logic             GNTA,
  output logic             GNTB,
  output logic [WIDTH-1:0] C,
  output logic             EN,
  output logic             OVF,
  output logic             SLEEP
);

  localparam int              IW        = idle_cnt_w(IDLE_CYC);
  localparam logic [WIDTH-1:0] STEP_A   = WIDTH'(STEPA);
  localparam logic [WIDTH-1:0] STEP_B   = WIDTH'(STEPB);
  localparam logic [IW-1:0]    IDLE_LAST = IW'(IDLE_CYC - 1);

  state_t        state;
  req_id_t       last;
  logic [IW-1:0] idle_cnt;
  logic [1:0]    gnt;
  req_id_t       gnt_id;
  logic [WIDTH:0] sum;

  rr_arb2 u_arb (
    .req    ({REQB, REQA}),
    .last   (last),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  // Extra MSB of the sum is the wrap indication.
  assign sum = {1'b0, C} + {1'b0, (gnt_id == ID_A) ? STEP_A : STEP_B};

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge ck) begin
    if (rst) begin
      state    <= S_RUN;
      last     <= ID_B;
      idle_cnt <= '0;
      C        <= '0;
      GNTA     <= 1'b0;
      GNTB     <= 1'b0;
      EN       <= 1'b0;
      OVF      <= 1'b0;
      SLEEP    <= 1'b0;
    end else begin
      GNTA <= 1'b0;
      GNTB <= 1'b0;
      EN   <= 1'b0;
      OVF  <= 1'b0;
      case (state)
        S_RUN: begin
          if (|gnt) begin
            GNTA     <= gnt[ID_A];
            GNTB     <= gnt[ID_B];
            EN       <= 1'b1;
            C        <= sum[WIDTH-1:0];
            OVF      <= sum[WIDTH];
            last     <= gnt_id;
            idle_cnt <= '0;
          end else if (idle_cnt == IDLE_LAST) begin
            state    <= S_SLEEP;
            SLEEP    <= 1'b1;
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        S_SLEEP: begin
          if (REQA || REQB) begin
            state <= S_WAKE;
            SLEEP <= 1'b0;
          end
        end
        // Requests seen here are not latched; they are re-sampled back in S_RUN.
        S_WAKE:  state <= S_RUN;
        default: state <= S_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_inc_sched.sv
// Directed self-checking bench for inc_sched: default instance plus a STEPA=16 instance for wrap.
module tb_inc_sched;

  logic       ck = 1'b0;
  logic       rst, rst16;
  logic       reqa, reqb, reqa16, reqb16;
  logic       gnta, gntb, en, ovf, sleep;
  logic       gnta16, gntb16, en16, ovf16, sleep16;
  logic [7:0] c, c16;

  int n_cmp = 0;
  int n_err = 0;

  always #5 ck = ~ck;

  inc_sched dut (
    .ck(ck), .rst(rst), .REQA(reqa), .REQB(reqb),
    .GNTA(gnta), .GNTB(gntb), .C(c), .EN(en), .OVF(ovf), .SLEEP(sleep)
  );

  inc_sched #(.STEPA(16)) dut16 (
    .ck(ck), .rst(rst16), .REQA(reqa16), .REQB(reqb16),
    .GNTA(gnta16), .GNTB(gntb16), .C(c16), .EN(en16), .OVF(ovf16), .SLEEP(sleep16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  // Checks the default instance: {GNTA,GNTB,EN,OVF,SLEEP} and C.
  task automatic expect_main(input string tag, input logic [4:0] flags, input logic [7:0] cnt);
    check({tag, ".flags"}, {27'd0, gnta, gntb, en, ovf, sleep}, {27'd0, flags});
    check({tag, ".C"}, {24'd0, c}, {24'd0, cnt});
  endtask

  initial begin
    rst = 1'b1; rst16 = 1'b1;
    reqa = 1'b1; reqb = 1'b1; reqa16 = 1'b0; reqb16 = 1'b0;

    // 1: reset with both requesting, then A alone
    tick(); tick();
    expect_main("reset", 5'b00000, 8'd0);
    rst = 1'b0; reqb = 1'b0;
    tick(); expect_main("a_only1", 5'b10100, 8'd1);
    tick(); expect_main("a_only2", 5'b10100, 8'd2);
    tick(); expect_main("a_only3", 5'b10100, 8'd3);

    // 2: both held, last=A -> B,A,B,A
    reqb = 1'b1;
    tick(); expect_main("alt_b1", 5'b01100, 8'd4);
    tick(); expect_main("alt_a1", 5'b10100, 8'd5);
    tick(); expect_main("alt_b2", 5'b01100, 8'd6);
    tick(); expect_main("alt_a2", 5'b10100, 8'd7);

    // 4: four request-free edges -> SLEEP
    reqa = 1'b0; reqb = 1'b0;
    tick(); expect_main("idle1", 5'b00000, 8'd7);
    tick(); expect_main("idle2", 5'b00000, 8'd7);
    tick(); expect_main("idle3", 5'b00000, 8'd7);
    tick(); expect_main("idle4_sleep", 5'b00001, 8'd7);
    tick(); expect_main("sleep_hold", 5'b00001, 8'd7);

    // 5: REQB wakes; wake cycle has no grant; grant one cycle later
    reqb = 1'b1;
    tick(); expect_main("wake_edge", 5'b00000, 8'd7);
    tick(); expect_main("wake_cycle", 5'b00000, 8'd7);
    tick(); expect_main("post_wake_b", 5'b01100, 8'd8);

    // 6: both requesting (last=B), then reset mid-stream with last=A
    reqa = 1'b1;
    tick(); expect_main("tie_a", 5'b10100, 8'd9);
    tick(); expect_main("tie_b", 5'b01100, 8'd10);
    tick(); expect_main("tie_a2", 5'b10100, 8'd11);
    rst = 1'b1;
    tick(); expect_main("mid_reset", 5'b00000, 8'd0);
    rst = 1'b0;
    tick(); expect_main("post_reset_tie", 5'b10100, 8'd1);
    tick(); expect_main("post_reset_tie2", 5'b01100, 8'd2);

    // 3: STEPA=16 wrap: 15 A-grants -> 0xF0, 8 B-grants -> 0xF8, then A wraps to 0x08
    reqa = 1'b0; reqb = 1'b0;
    tick();
    rst16 = 1'b0; reqa16 = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    check("wrap.base_C", {24'd0, c16}, 32'h0000_00F0);
    check("wrap.base_ovf", {31'd0, ovf16}, 32'd0);
    reqa16 = 1'b0; reqb16 = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    check("wrap.pre_C", {24'd0, c16}, 32'h0000_00F8);
    check("wrap.pre_gntb", {31'd0, gntb16}, 32'd1);
    reqa16 = 1'b1; reqb16 = 1'b0;
    tick();
    check("wrap.C", {24'd0, c16}, 32'h0000_0008);
    check("wrap.ovf", {31'd0, ovf16}, 32'd1);
    check("wrap.gnta", {30'd0, gnta16, gntb16}, 32'd2);
    tick();
    check("wrap.next_C", {24'd0, c16}, 32'h0000_0018);
    check("wrap.ovf_pulse", {31'd0, ovf16}, 32'd0);
    check("wrap.en", {31'd0, en16}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
